// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: holds the PC, issues one fetch at a time on the SRAM-like
// instruction bus and presents the fetched slot to the IF->ID register.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h1c000000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        id_allowin,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        wb_ex,
  input  logic [31:0] ex_entry,
  input  logic        wb_is_ertn,
  input  logic [31:0] era,
  output logic        inst_sram_req,
  output logic [31:0] inst_sram_addr,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata,
  output logic        if_ready_go,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_adef
);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic        discard;
  logic        discard_next;
  logic        started;
  logic        lock;
  logic [31:0] lock_addr;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        pc_misaligned;
  logic        accept;
  logic        capture;
  logic        adef_slot;

  assign redirect        = wb_ex | wb_is_ertn | br_taken;
  assign redirect_target = wb_ex      ? ex_entry :
                           wb_is_ertn ? era      : br_target;
  assign pc_misaligned   = (pc[1:0] != 2'b00);

  // A request that has not yet been accepted keeps its address even if pc is redirected.
  assign inst_sram_addr  = lock ? lock_addr : pc;
  assign inst_sram_req   = started && (state == S_REQ) && (lock || !pc_misaligned);
  assign accept          = inst_sram_req && inst_sram_addr_ok;
  assign if_ready_go     = (state == S_HOLD) && !redirect;

  always_comb begin
    state_next   = state;
    pc_next      = pc;
    discard_next = discard;
    capture      = 1'b0;
    adef_slot    = 1'b0;
    case (state)
      S_REQ: begin
        if (accept) begin
          state_next = S_WAIT;
        end else if (!lock && pc_misaligned && !redirect) begin
          state_next = S_HOLD;
          adef_slot  = 1'b1;
        end
        if (redirect && inst_sram_req) begin
          discard_next = 1'b1;
        end
      end
      S_WAIT: begin
        if (inst_sram_data_ok) begin
          if (discard || redirect) begin
            discard_next = 1'b0;
            state_next   = S_REQ;
          end else begin
            capture    = 1'b1;
            state_next = S_HOLD;
          end
        end else if (redirect) begin
          discard_next = 1'b1;
        end
      end
      S_HOLD: begin
        if (redirect) begin
          state_next = S_REQ;
        end else if (id_allowin) begin
          state_next = S_REQ;
          pc_next    = pc + 32'd4;
        end
      end
      default: state_next = S_REQ;
    endcase
    if (redirect) begin
      pc_next = redirect_target;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= S_REQ;
      pc        <= RESET_PC;
      discard   <= 1'b0;
      started   <= 1'b0;
      lock      <= 1'b0;
      lock_addr <= RESET_PC;
    end else begin
      state     <= state_next;
      pc        <= pc_next;
      discard   <= discard_next;
      started   <= 1'b1;
      if (inst_sram_req && !inst_sram_addr_ok) begin
        lock      <= 1'b1;
        lock_addr <= inst_sram_addr;
      end else begin
        lock      <= 1'b0;
      end
    end
  end

  // Delivered slot: either real fetched data or an ADEF marker for a misaligned pc.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      if_pc   <= RESET_PC;
      if_inst <= 32'd0;
      if_adef <= 1'b0;
    end else if (capture) begin
      if_pc   <= pc;
      if_inst <= inst_sram_rdata;
      if_adef <= 1'b0;
    end else if (adef_slot) begin
      if_pc   <= pc;
      if_inst <= 32'd0;
      if_adef <= 1'b1;
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: a small SRAM responder returns addr ^ 32'h5a5a0f0f
// after a programmable latency, and each step checks outputs against hand-computed values.
module tb_if_fetch_stage;

  logic        clk;
  logic        resetn;
  logic        id_allowin;
  logic        br_taken;
  logic [31:0] br_target;
  logic        wb_ex;
  logic [31:0] ex_entry;
  logic        wb_is_ertn;
  logic [31:0] era;
  logic        inst_sram_req;
  logic [31:0] inst_sram_addr;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        if_ready_go;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_adef;

  int          vectors;
  int          miscompares;
  bit          pend;
  int          cnt;
  int          lat;
  logic [31:0] pend_addr;

  if_fetch_stage #(.RESET_PC(32'h1c000000)) dut (
    .clk               (clk),
    .resetn            (resetn),
    .id_allowin        (id_allowin),
    .br_taken          (br_taken),
    .br_target         (br_target),
    .wb_ex             (wb_ex),
    .ex_entry          (ex_entry),
    .wb_is_ertn        (wb_is_ertn),
    .era               (era),
    .inst_sram_req     (inst_sram_req),
    .inst_sram_addr    (inst_sram_addr),
    .inst_sram_addr_ok (inst_sram_addr_ok),
    .inst_sram_data_ok (inst_sram_data_ok),
    .inst_sram_rdata   (inst_sram_rdata),
    .if_ready_go       (if_ready_go),
    .if_pc             (if_pc),
    .if_inst           (if_inst),
    .if_adef           (if_adef)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkFlag(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Advance one cycle; the responder sees the handshake that happens at this edge.
  task automatic applyStimulus();
    logic        hs;
    logic [31:0] hs_addr;
    hs      = inst_sram_req && inst_sram_addr_ok;
    hs_addr = inst_sram_addr;
    checkFlag("single_outstanding", hs && pend, 1'b0);
    @(posedge clk);
    #1;
    inst_sram_data_ok = 1'b0;
    inst_sram_rdata   = 32'd0;
    if (hs) begin
      pend      = 1'b1;
      pend_addr = hs_addr;
      cnt       = lat;
    end
    if (pend) begin
      cnt = cnt - 1;
      if (cnt == 0) begin
        inst_sram_data_ok = 1'b1;
        inst_sram_rdata   = pend_addr ^ 32'h5a5a0f0f;
        pend              = 1'b0;
      end
    end
    #1;
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    pend = 1'b0; cnt = 0; lat = 1; pend_addr = 32'd0;
    resetn = 1'b1; id_allowin = 1'b0;
    br_taken = 1'b0; br_target = 32'd0;
    wb_ex = 1'b0; ex_entry = 32'd0;
    wb_is_ertn = 1'b0; era = 32'd0;
    inst_sram_addr_ok = 1'b0; inst_sram_data_ok = 1'b0; inst_sram_rdata = 32'd0;
    #1 resetn = 1'b0;
    #1;
    checkFlag("rst_req", inst_sram_req, 1'b0);
    checkOutput("rst_addr", inst_sram_addr, 32'h1c000000);
    checkFlag("rst_ready_go", if_ready_go, 1'b0);
    checkOutput("rst_if_pc", if_pc, 32'h1c000000);
    checkOutput("rst_if_inst", if_inst, 32'd0);
    checkFlag("rst_if_adef", if_adef, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    checkFlag("rst_held_req", inst_sram_req, 1'b0);
    resetn = 1'b1;
    #1;
    checkFlag("release_req", inst_sram_req, 1'b0);
    applyStimulus();
    checkFlag("first_req", inst_sram_req, 1'b1);
    checkOutput("first_addr", inst_sram_addr, 32'h1c000000);

    // Basic fetch: addr_ok=1, one-cycle data.
    inst_sram_addr_ok = 1'b1;
    applyStimulus();
    checkFlag("wait_req", inst_sram_req, 1'b0);
    checkFlag("wait_ready_go", if_ready_go, 1'b0);
    applyStimulus();
    checkFlag("hold_ready_go", if_ready_go, 1'b1);
    checkOutput("hold_if_pc", if_pc, 32'h1c000000);
    checkOutput("hold_if_inst", if_inst, 32'h465a0f0f);
    checkFlag("hold_if_adef", if_adef, 1'b0);

    // ID stalls for 5 cycles: slot stays put and no new request goes out.
    for (int i = 0; i < 5; i++) begin
      applyStimulus();
      checkFlag("stall_ready_go", if_ready_go, 1'b1);
      checkFlag("stall_req", inst_sram_req, 1'b0);
      checkOutput("stall_if_pc", if_pc, 32'h1c000000);
      checkOutput("stall_if_inst", if_inst, 32'h465a0f0f);
    end

    // Branch while waiting on a 3-cycle response.
    id_allowin = 1'b1; lat = 3;
    applyStimulus();
    id_allowin = 1'b0;
    checkOutput("seq_addr", inst_sram_addr, 32'h1c000004);
    checkFlag("seq_ready_go", if_ready_go, 1'b0);
    applyStimulus();
    br_taken = 1'b1; br_target = 32'h1c000100;
    #1;
    checkFlag("br_wait_ready_go", if_ready_go, 1'b0);
    applyStimulus();
    br_taken = 1'b0;
    applyStimulus();
    checkFlag("br_data_ok", inst_sram_data_ok, 1'b1);
    checkFlag("br_drop_ready_go", if_ready_go, 1'b0);
    applyStimulus();
    checkFlag("br_after_ready_go", if_ready_go, 1'b0);
    checkFlag("br_req", inst_sram_req, 1'b1);
    checkOutput("br_addr", inst_sram_addr, 32'h1c000100);
    lat = 1;
    applyStimulus();
    applyStimulus();
    checkFlag("br_hold_ready_go", if_ready_go, 1'b1);
    checkOutput("br_hold_if_pc", if_pc, 32'h1c000100);
    checkOutput("br_hold_if_inst", if_inst, 32'h465a0e0f);

    // addr_ok withheld, then an exception flush while the request is pending.
    inst_sram_addr_ok = 1'b0; id_allowin = 1'b1;
    applyStimulus();
    id_allowin = 1'b0;
    checkFlag("stall_acc_req", inst_sram_req, 1'b1);
    checkOutput("stall_acc_addr0", inst_sram_addr, 32'h1c000104);
    applyStimulus();
    applyStimulus();
    applyStimulus();
    wb_ex = 1'b1; ex_entry = 32'h1c008000;
    #1;
    checkFlag("ex_ready_go", if_ready_go, 1'b0);
    applyStimulus();
    wb_ex = 1'b0;
    checkFlag("ex_lock_req", inst_sram_req, 1'b1);
    checkOutput("ex_lock_addr", inst_sram_addr, 32'h1c000104);
    applyStimulus();
    checkOutput("ex_lock_addr2", inst_sram_addr, 32'h1c000104);
    inst_sram_addr_ok = 1'b1;
    applyStimulus();
    checkFlag("ex_stale_data_ok", inst_sram_data_ok, 1'b1);
    applyStimulus();
    checkFlag("ex_drop_ready_go", if_ready_go, 1'b0);
    checkFlag("ex_new_req", inst_sram_req, 1'b1);
    checkOutput("ex_new_addr", inst_sram_addr, 32'h1c008000);
    applyStimulus();
    applyStimulus();
    checkOutput("ex_hold_if_pc", if_pc, 32'h1c008000);
    checkOutput("ex_hold_if_inst", if_inst, 32'h465a8f0f);

    // All three redirects together, with a transfer attempt that must be suppressed.
    wb_ex = 1'b1; ex_entry = 32'h1c000200;
    wb_is_ertn = 1'b1; era = 32'h1c000300;
    br_taken = 1'b1; br_target = 32'h1c000400;
    id_allowin = 1'b1;
    #1;
    checkFlag("prio_ready_go", if_ready_go, 1'b0);
    applyStimulus();
    wb_ex = 1'b0; wb_is_ertn = 1'b0; br_taken = 1'b0; id_allowin = 1'b0;
    checkOutput("prio_addr", inst_sram_addr, 32'h1c000200);
    applyStimulus();
    applyStimulus();
    checkOutput("prio_if_pc", if_pc, 32'h1c000200);
    checkOutput("prio_if_inst", if_inst, 32'h465a0d0f);

    // ertn to a misaligned address yields an ADEF slot without any request.
    wb_is_ertn = 1'b1; era = 32'h1c000002;
    applyStimulus();
    wb_is_ertn = 1'b0;
    checkFlag("adef_no_req", inst_sram_req, 1'b0);
    applyStimulus();
    checkFlag("adef_ready_go", if_ready_go, 1'b1);
    checkFlag("adef_flag", if_adef, 1'b1);
    checkOutput("adef_if_inst", if_inst, 32'd0);
    checkOutput("adef_if_pc", if_pc, 32'h1c000002);
    checkFlag("adef_hold_req", inst_sram_req, 1'b0);

    // PC wraps from the last word to zero.
    br_taken = 1'b1; br_target = 32'hfffffffc;
    applyStimulus();
    br_taken = 1'b0;
    checkOutput("wrap_top_addr", inst_sram_addr, 32'hfffffffc);
    applyStimulus();
    applyStimulus();
    checkOutput("wrap_if_pc", if_pc, 32'hfffffffc);
    checkOutput("wrap_if_inst", if_inst, 32'ha5a5f0f3);
    checkFlag("wrap_if_adef", if_adef, 1'b0);
    id_allowin = 1'b1;
    applyStimulus();
    id_allowin = 1'b0;
    checkFlag("wrap_req", inst_sram_req, 1'b1);
    checkOutput("wrap_addr", inst_sram_addr, 32'h00000000);

    // Reset in the middle of a transaction.
    applyStimulus();
    resetn = 1'b0;
    #1;
    checkFlag("midrst_req", inst_sram_req, 1'b0);
    checkOutput("midrst_addr", inst_sram_addr, 32'h1c000000);
    checkFlag("midrst_ready_go", if_ready_go, 1'b0);
    checkOutput("midrst_if_pc", if_pc, 32'h1c000000);
    pend = 1'b0; inst_sram_data_ok = 1'b0; inst_sram_rdata = 32'd0;
    applyStimulus();
    resetn = 1'b1;
    applyStimulus();
    checkFlag("postrst_req", inst_sram_req, 1'b1);
    checkOutput("postrst_addr", inst_sram_addr, 32'h1c000000);
    applyStimulus();
    applyStimulus();
    checkFlag("postrst_ready_go", if_ready_go, 1'b1);
    checkOutput("postrst_if_pc", if_pc, 32'h1c000000);
    checkOutput("postrst_if_inst", if_inst, 32'h465a0f0f);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
